// File: rtl/omsp_spm_key_sequencer.sv
// Pulls KEY_WORDS words from the key-derivation engine and replays each one as
// a single-cycle write strobe into the SPM key array, with timeout and abort.
module omsp_spm_key_sequencer #(
  parameter int KEY_WORDS    = 4,
  parameter int KEY_IDX_SIZE = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    kd_valid,
  input  logic [15:0]             kd_data,
  output logic                    kd_ready,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_WORDS - 1);
  localparam logic [15:0]             LAST_TMR = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [KEY_IDX_SIZE-1:0] idx_q, idx_d;
  logic [15:0]             timer_q, timer_d;
  logic [15:0]             key_in_q, key_in_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      key_in_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      key_in_q <= key_in_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    key_in_d = key_in_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      ST_LOAD: begin
        // A word arriving in the timeout cycle still wins over the error.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (kd_valid) begin
          key_in_d = kd_data;
          timer_d  = '0;
          state_d  = ST_WRITE;
        end else if (timer_q == LAST_TMR) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign kd_ready  = (state_q == ST_LOAD);
  assign write_key = (state_q == ST_WRITE);
  assign busy      = (state_q != ST_IDLE);
  assign key_in    = key_in_q;
  assign key_idx   = idx_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_omsp_spm_key_sequencer.sv
// Directed bench for the key sequencer: one instance at default TIMEOUT, one
// at TIMEOUT=5 for the timeout and boundary-timeout cases.
module tb_omsp_spm_key_sequencer;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        start, abort, kd_valid;
  logic [15:0] kd_data;
  logic        kd_ready, write_key, busy, done, error;
  logic [15:0] key_in;
  logic [1:0]  key_idx;

  logic        start5, abort5, kd_valid5;
  logic [15:0] kd_data5;
  logic        kd_ready5, write_key5, busy5, done5, error5;
  logic [15:0] key_in5;
  logic [1:0]  key_idx5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 mclk = ~mclk;

  omsp_spm_key_sequencer u_dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .abort(abort),
    .kd_valid(kd_valid), .kd_data(kd_data), .kd_ready(kd_ready),
    .write_key(write_key), .key_in(key_in), .key_idx(key_idx),
    .busy(busy), .done(done), .error(error)
  );

  omsp_spm_key_sequencer #(.KEY_WORDS(4), .KEY_IDX_SIZE(2), .TIMEOUT(5)) u_dut5 (
    .mclk(mclk), .puc_rst(puc_rst), .start(start5), .abort(abort5),
    .kd_valid(kd_valid5), .kd_data(kd_data5), .kd_ready(kd_ready5),
    .write_key(write_key5), .key_in(key_in5), .key_idx(key_idx5),
    .busy(busy5), .done(done5), .error(error5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  initial begin
    logic [15:0] words [4];
    int wr_cnt, done_cnt, err_cnt;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;

    puc_rst = 1'b1;
    start = 0; abort = 0; kd_valid = 0; kd_data = 0;
    start5 = 0; abort5 = 0; kd_valid5 = 0; kd_data5 = 0;
    tick(); tick();
    puc_rst = 1'b0;
    chk("rst_kd_ready", kd_ready, 0);
    chk("rst_write_key", write_key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_key_in", key_in, 0);
    chk("rst_key_idx", key_idx, 0);
    chk("rst5_busy", busy5, 0);

    // Full-rate load: start sampled at edge 0, writes in cycles 2/4/6/8.
    start = 1; kd_valid = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fr_load%0d_busy", k), busy, 1);
      chk($sformatf("fr_load%0d_ready", k), kd_ready, 1);
      chk($sformatf("fr_load%0d_done", k), done, 0);
      kd_data = words[k];
      tick();
      chk($sformatf("fr_wr%0d_strobe", k), write_key, 1);
      chk($sformatf("fr_wr%0d_idx", k), key_idx, k);
      chk($sformatf("fr_wr%0d_data", k), key_in, words[k]);
      chk($sformatf("fr_wr%0d_ready", k), kd_ready, 0);
      tick();
    end
    chk("fr_done_c9", done, 1);
    chk("fr_busy_c9", busy, 1);
    chk("fr_wr_c9", write_key, 0);
    tick();
    chk("fr_busy_c10", busy, 0);
    chk("fr_done_c10", done, 0);
    chk("fr_key_in_hold", key_in, 16'h4444);

    // Reset in the middle of a load.
    kd_valid = 0;
    start = 1;
    tick();
    start = 0;
    tick();
    chk("mid_rst_in_load", kd_ready, 1);
    puc_rst = 1;
    tick();
    puc_rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", kd_ready, 0);
    chk("mid_rst_key_in", key_in, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    tick();
    chk("mid_rst_after_done", done, 0);
    chk("mid_rst_after_error", error, 0);

    // Stalled source: 10 idle LOAD cycles before each word.
    err_cnt = 0;
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      kd_valid = 0;
      for (int s = 0; s < 10; s++) begin
        if (error || write_key || !kd_ready) err_cnt++;
        tick();
      end
      kd_valid = 1; kd_data = words[3-k];
      tick();
      kd_valid = 0;
      chk($sformatf("st_wr%0d_strobe", k), write_key, 1);
      chk($sformatf("st_wr%0d_idx", k), key_idx, k);
      chk($sformatf("st_wr%0d_data", k), key_in, words[3-k]);
      tick();
    end
    chk("st_stall_glitches", err_cnt, 0);
    chk("st_done", done, 1);
    tick();
    chk("st_done_once", done, 0);
    chk("st_idle", busy, 0);

    // Timeout: LOAD entered in cycle 1, error in cycle 6.
    start5 = 1;
    tick();
    start5 = 0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("to_c%0d_busy", c), busy5, 1);
      chk($sformatf("to_c%0d_err", c), error5, 0);
    end
    for (int c = 1; c <= 4; c++) tick();
    tick();
    chk("to_error", error5, 1);
    chk("to_busy_low", busy5, 0);
    chk("to_no_write", write_key5, 0);
    chk("to_no_done", done5, 0);
    tick();
    chk("to_error_pulse", error5, 0);
    chk("to_busy_after", busy5, 0);

    // Boundary: kd_valid arrives in the timeout cycle.
    start5 = 1;
    tick();
    start5 = 0;
    for (int c = 1; c <= 4; c++) tick();
    kd_valid5 = 1; kd_data5 = 16'hABCD;
    tick();
    kd_valid5 = 0;
    chk("bt_no_error", error5, 0);
    chk("bt_write", write_key5, 1);
    chk("bt_key_in", key_in5, 16'hABCD);
    chk("bt_idx", key_idx5, 0);
    abort5 = 1;
    tick();
    abort5 = 0;
    chk("bt_abort_idle", busy5, 0);
    chk("bt_abort_no_err", error5, 0);

    // Abort in the cycle after the 2nd write (cycle 5).
    kd_valid = 1; kd_data = 16'h5A5A;
    start = 1;
    tick();
    start = 0;
    for (int c = 1; c < 5; c++) tick();
    chk("ab_c5_load", kd_ready, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("ab_idle", busy, 0);
    wr_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      wr_cnt += int'(write_key);
      done_cnt += int'(done);
      tick();
    end
    chk("ab_no_writes", wr_cnt, 0);
    chk("ab_no_done", done_cnt, 0);

    // start pulses while busy (cycle 3 LOAD, cycle 9 DONE) are ignored.
    start = 1;
    tick();
    start = 0;
    wr_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      start = (c == 3 || c == 9);
      wr_cnt += int'(write_key);
      done_cnt += int'(done);
      tick();
    end
    start = 0;
    chk("ig_writes", wr_cnt, 4);
    chk("ig_done", done_cnt, 1);
    chk("ig_not_requeued", busy, 0);

    // start with abort in IDLE.
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    chk("sa_idle_busy", busy, 0);
    chk("sa_idle_ready", kd_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
